fsm_decoder: RTL and testbench



---
 rtl/fsm_decoder.sv | 147 ++++++++++++++
 tb/tb_fsm_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fsm_decoder.sv
// fsm_decoder: trace observer for the two-input Mealy control FSM (S0..S4).
// Consumes the FSM's m/n/p output stream, tracks its state, reconstructs the
// a/b input condition behind each sample and flags codes that cannot occur.
//
// Handshake: a sample is consumed on any rising edge where in_valid=1 (no
// stall, no ready). The decoded result appears one cycle later with
// out_valid=1; when in_valid=0, out_valid and err drop and all other
// outputs hold their previous values.
//
// Build option: define FSM_DECODER_RESYNC_EN to return the tracker to S0 on
// an illegal sample; otherwise an illegal sample locks it in ERR until rst.
module fsm_decoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 m,
    input  logic                 n,
    input  logic                 p,
    output logic                 out_valid,
    output logic                 a_out,
    output logic                 b_out,
    output logic                 a_known,
    output logic                 b_known,
    output logic [2:0]           state,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        S0  = 3'd0,
        S1  = 3'd1,
        S2  = 3'd2,
        S3  = 3'd3,
        S4  = 3'd4,
        ERR = 3'd7
    } state_t;

`ifdef FSM_DECODER_RESYNC_EN
    localparam state_t ILLEGAL_NEXT = S0;
`else
    localparam state_t ILLEGAL_NEXT = ERR;
`endif

    state_t     cur_q;
    state_t     nxt;
    logic [2:0] code;
    logic       illegal;
    logic       dec_ak;
    logic       dec_av;
    logic       dec_bk;
    logic       dec_bv;

    assign code  = {m, n, p};
    assign state = cur_q;

    // Tracked state register; advances only on a valid sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q <= S0;
        end else if (in_valid) begin
            cur_q <= nxt;
        end
    end

    // Decode the sample against the tracked state: legality, inputs, next state.
    always_comb begin
        illegal = 1'b1;
        dec_ak  = 1'b0;
        dec_av  = 1'b0;
        dec_bk  = 1'b0;
        dec_bv  = 1'b0;
        nxt     = ILLEGAL_NEXT;
        unique case (cur_q)
            S0: begin
                if (code == 3'b100) begin
                    illegal = 1'b0; dec_ak = 1'b1; dec_av = 1'b1; nxt = S1;
                end else if (code == 3'b001) begin
                    illegal = 1'b0; dec_ak = 1'b1; dec_av = 1'b0; nxt = S1;
                end
            end
            S1: begin
                if (code == 3'b010) begin
                    illegal = 1'b0; dec_bk = 1'b1; dec_bv = 1'b1; nxt = S2;
                end else if (code == 3'b110) begin
                    illegal = 1'b0; dec_ak = 1'b1; dec_av = 1'b1;
                    dec_bk  = 1'b1; nxt = S3;
                end else if (code == 3'b100) begin
                    illegal = 1'b0; dec_ak = 1'b1; dec_bk = 1'b1; nxt = S4;
                end
            end
            S2: begin
                if (code == 3'b101) begin
                    illegal = 1'b0; dec_ak = 1'b1; dec_bk = 1'b1; nxt = S2;
                end else if (code == 3'b010) begin
                    // a|b=1: neither bit individually determined.
                    illegal = 1'b0; nxt = S3;
                end
            end
            S3: begin
                if (code == 3'b000) begin
                    illegal = 1'b0; dec_bk = 1'b1; dec_bv = 1'b1; nxt = S1;
                end else if (code == 3'b001) begin
                    illegal = 1'b0; dec_bk = 1'b1; dec_bv = 1'b0; nxt = S3;
                end
            end
            S4: begin
                if (code == 3'b010) begin
                    illegal = 1'b0; nxt = S3;
                end
            end
            default: begin
                // ERR: every sample is illegal and the tracker stays locked.
                illegal = 1'b1;
                nxt     = ILLEGAL_NEXT;
            end
        endcase
    end

    // Registered result outputs and saturating illegal-sample counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            a_known   <= 1'b0;
            b_known   <= 1'b0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            err       <= illegal;
            a_known   <= dec_ak;
            a_out     <= dec_ak & dec_av;
            b_known   <= dec_bk;
            b_out     <= dec_bk & dec_bv;
            if (illegal && (err_cnt != {ERR_CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fsm_decoder.sv
// tb_fsm_decoder: directed trace bench for fsm_decoder (counter width 2 so
// saturation is reachable). Stimulus pushes the hand-computed result of each
// sample into exp_q; the monitor pops on out_valid and, on idle cycles,
// checks that outputs hold and out_valid/err are low.
module tb_fsm_decoder;

    localparam int CW    = 2;
    localparam int EXP_W = 3 + 4 + 1 + CW;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          m;
    logic          n;
    logic          p;
    logic          out_valid;
    logic          a_out;
    logic          b_out;
    logic          a_known;
    logic          b_known;
    logic [2:0]    state;
    logic          err;
    logic [CW-1:0] err_cnt;

    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] hold;
    logic             mon_en;
    int               checks;
    int               errors;

    fsm_decoder #(.ERR_CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .m         (m),
        .n         (n),
        .p         (p),
        .out_valid (out_valid),
        .a_out     (a_out),
        .b_out     (b_out),
        .a_known   (a_known),
        .b_known   (b_known),
        .state     (state),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    // Clock and reset defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected packing: {state, a_known, a_out, b_known, b_out, err, err_cnt}
    function automatic logic [EXP_W-1:0] pack(input logic [2:0] st, input logic [3:0] kv,
                                              input logic e, input logic [CW-1:0] c);
        return {st, kv, e, c};
    endfunction

    // Drive one valid sample and queue its expected result.
    task automatic drive(input logic [2:0] code, input logic [2:0] st, input logic [3:0] kv,
                         input logic e, input logic [CW-1:0] c);
        {m, n, p} = code;
        in_valid  = 1'b1;
        exp_q.push_back(pack(st, kv, e, c));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        in_valid = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset for the given number of cycles, optionally with a valid sample present.
    task automatic do_reset(input int cycles, input logic with_sample, input logic [2:0] code);
        rst       = 1'b1;
        in_valid  = with_sample;
        {m, n, p} = code;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            hold   = '0;
            mon_en = 1'b1;
        end
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    // Monitor: pop and compare on out_valid, otherwise check held outputs.
    always @(negedge clk) begin
        logic [EXP_W-1:0] act;
        logic [EXP_W-1:0] e;
        if (mon_en) begin
            act = {state, a_known, a_out, b_known, b_out, err, err_cnt};
            checks++;
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output t=%0t act=%b required=no output", $time, act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL sample_result t=%0t act=%b required=%b", $time, act, e);
                    end
                    hold     = e;
                    hold[CW] = 1'b0;
                end
            end else if (out_valid !== 1'b0 || act !== hold) begin
                errors++;
                $display("FAIL idle_hold t=%0t out_valid=%b act=%b required=0/%b",
                         $time, out_valid, act, hold);
            end
        end
    end

    // Legal trace from S0 with optional idle gaps between samples.
    task automatic legal_trace(input int gap);
        drive(3'b100, 3'd1, 4'b1100, 1'b0, 2'd0); idle(gap);
        drive(3'b010, 3'd2, 4'b0011, 1'b0, 2'd0); idle(gap);
        drive(3'b101, 3'd2, 4'b1010, 1'b0, 2'd0); idle(gap);
        drive(3'b010, 3'd3, 4'b0000, 1'b0, 2'd0); idle(gap);
        drive(3'b001, 3'd3, 4'b0010, 1'b0, 2'd0); idle(gap);
        drive(3'b000, 3'd1, 4'b0011, 1'b0, 2'd0); idle(gap);
        drive(3'b100, 3'd4, 4'b1010, 1'b0, 2'd0); idle(gap);
        drive(3'b010, 3'd3, 4'b0000, 1'b0, 2'd0); idle(gap);
    endtask

    // Directed stimulus sequence and final report
    initial begin
        logic [2:0] err_state;
        checks    = 0;
        errors    = 0;
        mon_en    = 1'b0;
        hold      = '0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        {m, n, p} = 3'b000;
`ifdef FSM_DECODER_RESYNC_EN
        err_state = 3'd0;
`else
        err_state = 3'd7;
`endif
        @(posedge clk);
        #1;

        // Reset values, then idle
        do_reset(2, 1'b0, 3'b000);
        idle(2);

        // Back-to-back legal trace
        legal_trace(0);
        idle(2);

        // Same trace with idle gaps
        do_reset(1, 1'b0, 3'b000);
        legal_trace(1);
        idle(1);

        // Illegal code from S0
        do_reset(1, 1'b0, 3'b000);
        drive(3'b010, err_state, 4'b0000, 1'b1, 2'd1);
        idle(1);
`ifdef FSM_DECODER_RESYNC_EN
        drive(3'b001, 3'd1, 4'b1000, 1'b0, 2'd1);
`else
        drive(3'b001, 3'd7, 4'b0000, 1'b1, 2'd2);
`endif
        idle(2);

        // Reset while a valid sample is presented from S4
        do_reset(1, 1'b0, 3'b000);
        drive(3'b100, 3'd1, 4'b1100, 1'b0, 2'd0);
        drive(3'b100, 3'd4, 4'b1010, 1'b0, 2'd0);
        do_reset(1, 1'b1, 3'b010);
        idle(2);
        drive(3'b100, 3'd1, 4'b1100, 1'b0, 2'd0);
        idle(1);

        // Counter saturation
        do_reset(1, 1'b0, 3'b000);
        drive(3'b010, err_state, 4'b0000, 1'b1, 2'd1);
        drive(3'b010, err_state, 4'b0000, 1'b1, 2'd2);
        drive(3'b010, err_state, 4'b0000, 1'b1, 2'd3);
        drive(3'b010, err_state, 4'b0000, 1'b1, 2'd3);
        drive(3'b010, err_state, 4'b0000, 1'b1, 2'd3);
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL results_drained pending=%0d required=0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
